// File: rtl/div_unit_pkg.sv
// Shared state encodings and handshake constants for the iterative divider.
package div_unit_pkg;

  // Divider control states, two-bit encoding.
  typedef enum logic [1:0] {
    ST_FREE    = 2'b00,
    ST_BY_ZERO = 2'b01,
    ST_ON      = 2'b10,
    ST_END     = 2'b11
  } div_state_e;

  // Handshake levels used on ready_o and start_i.
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between the EX stage (master) and the divider (slave).
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               start_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;
  logic               div_by_zero_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, div_by_zero_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, div_by_zero_o
  );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider, signed or unsigned.
// Result is {remainder, quotient}; all outputs come straight from flops.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  div_unit_if.slave   bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  div_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;
  logic               dbz_q, dbz_d;

  logic [2*WIDTH:0]   shifted;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   abs1, abs2;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic               op1_neg, op2_neg;

  // Operand magnitudes, one restoring step and the final sign fix-up.
  always_comb begin
    op1_neg = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
    op2_neg = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
    abs1    = op1_neg ? -bus.opdata1_i : bus.opdata1_i;
    abs2    = op2_neg ? -bus.opdata2_i : bus.opdata2_i;
    shifted = {acc_q, 1'b0};
    diff    = shifted[2*WIDTH:WIDTH] - {1'b0, divisor_q};
    quo_fix = neg_quo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  // Next-state and datapath control; every register holds unless told otherwise.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    divisor_d = divisor_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    ready_d   = ready_q;
    dbz_d     = dbz_q;
    case (state_q)
      ST_FREE: begin
        if (bus.start_i == DIV_START && !bus.annul_i) begin
          neg_quo_d = op1_neg ^ op2_neg;
          neg_rem_d = op1_neg;
          acc_d     = {{WIDTH{1'b0}}, abs1};
          divisor_d = abs2;
          cnt_d     = '0;
          state_d   = (bus.opdata2_i == '0) ? ST_BY_ZERO : ST_ON;
        end
      end
      ST_BY_ZERO: begin
        if (bus.annul_i) begin
          cnt_d   = '0;
          state_d = ST_FREE;
        end else if (cnt_q == CW'(1)) begin
          result_d = '0;
          ready_d  = DIV_RESULT_READY;
          dbz_d    = 1'b1;
          state_d  = ST_END;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_ON: begin
        if (bus.annul_i) begin
          cnt_d   = '0;
          state_d = ST_FREE;
        end else if (cnt_q == CW'(WIDTH)) begin
          result_d = {rem_fix, quo_fix};
          ready_d  = DIV_RESULT_READY;
          dbz_d    = 1'b0;
          state_d  = ST_END;
        end else begin
          acc_d = diff[WIDTH] ? shifted[2*WIDTH-1:0]
                              : {diff[WIDTH-1:0], shifted[WIDTH-1:1], 1'b1};
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_END: begin
        if (bus.start_i == DIV_STOP) begin
          result_d = '0;
          ready_d  = DIV_RESULT_NOT_READY;
          dbz_d    = 1'b0;
          state_d  = ST_FREE;
        end
      end
      default: state_d = ST_FREE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FREE;
      cnt_q     <= '0;
      acc_q     <= '0;
      divisor_q <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= DIV_RESULT_NOT_READY;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      divisor_q <= divisor_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
      dbz_q     <= dbz_d;
    end
  end

  assign bus.result_o      = result_q;
  assign bus.ready_o       = ready_q;
  assign bus.div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit at WIDTH=32 and WIDTH=8.
module tb_div_unit;

  logic clk;
  logic rst;
  int   tests;
  int   failed;

  div_unit_if #(.WIDTH(32)) if32 ();
  div_unit_if #(.WIDTH(8))  if8 ();

  div_unit #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(if32.slave));
  div_unit #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8.slave));

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference quotient/remainder from plain language arithmetic.
  function automatic logic [63:0] model32(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint q, r;
    logic [63:0] qv, rv;
    if (b == 0) return 64'd0;
    if (sgn) begin
      q = longint'($signed(a)) / longint'($signed(b));
      r = longint'($signed(a)) % longint'($signed(b));
    end else begin
      q = longint'({32'd0, a / b});
      r = longint'({32'd0, a % b});
    end
    qv = q;
    rv = r;
    return {rv[31:0], qv[31:0]};
  endfunction

  function automatic logic [15:0] model8(input bit sgn, input logic [7:0] a, input logic [7:0] b);
    int q, r;
    logic [31:0] qv, rv;
    if (b == 0) return 16'd0;
    if (sgn) begin
      q = int'($signed(a)) / int'($signed(b));
      r = int'($signed(a)) % int'($signed(b));
    end else begin
      q = int'({24'd0, a}) / int'({24'd0, b});
      r = int'({24'd0, a}) % int'({24'd0, b});
    end
    qv = q;
    rv = r;
    return {rv[7:0], qv[7:0]};
  endfunction

  // Issue a 32-bit divide and wait for ready; operands are scrambled after t0.
  task automatic run32(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                       output logic [63:0] res, output bit dbz, output int lat);
    if32.signed_div_i = sgn;
    if32.opdata1_i    = a;
    if32.opdata2_i    = b;
    if32.start_i      = 1'b1;
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        if32.opdata1_i    = $urandom;
        if32.opdata2_i    = $urandom;
        if32.signed_div_i = ~sgn;
      end
      if (if32.ready_o === 1'b1) begin
        lat = c;
        break;
      end
    end
    res = if32.result_o;
    dbz = if32.div_by_zero_o;
  endtask

  // Same as run32 for the 8-bit instance.
  task automatic run8(input bit sgn, input logic [7:0] a, input logic [7:0] b,
                      output logic [15:0] res, output bit dbz, output int lat);
    if8.signed_div_i = sgn;
    if8.opdata1_i    = a;
    if8.opdata2_i    = b;
    if8.start_i      = 1'b1;
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        if8.opdata1_i    = 8'($urandom);
        if8.opdata2_i    = 8'($urandom);
        if8.signed_div_i = ~sgn;
      end
      if (if8.ready_o === 1'b1) begin
        lat = c;
        break;
      end
    end
    res = if8.result_o;
    dbz = if8.div_by_zero_o;
  endtask

  // Drop start and let one edge pass.
  task automatic release_all();
    if32.start_i = 1'b0;
    if8.start_i  = 1'b0;
    @(posedge clk); #1;
  endtask

  // Outputs after a reset.
  task automatic test_reset();
    rst = 1'b1;
    if32.start_i = 1'b0; if32.annul_i = 1'b0; if32.signed_div_i = 1'b0;
    if32.opdata1_i = '0; if32.opdata2_i = '0;
    if8.start_i = 1'b0; if8.annul_i = 1'b0; if8.signed_div_i = 1'b0;
    if8.opdata1_i = '0; if8.opdata2_i = '0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({if32.ready_o, if32.div_by_zero_o, if32.result_o} !== 66'd0) begin
      failed++;
      $display("[TB] FAIL reset32 got %h want 0", {if32.ready_o, if32.div_by_zero_o, if32.result_o});
    end
    tests++;
    if ({if8.ready_o, if8.div_by_zero_o, if8.result_o} !== 18'd0) begin
      failed++;
      $display("[TB] FAIL reset8 got %h want 0", {if8.ready_o, if8.div_by_zero_o, if8.result_o});
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Unsigned divides: fixed case with latency, then random operands.
  task automatic test_unsigned();
    logic [63:0] res, exp;
    logic [31:0] a, b;
    bit dbz;
    int lat;
    run32(1'b0, 32'd100, 32'd7, res, dbz, lat);
    tests++;
    if (res !== {32'h2, 32'hE}) begin
      failed++; $display("[TB] FAIL udiv_100_7 got %h want %h", res, {32'h2, 32'hE});
    end
    tests++;
    if (lat !== 34) begin
      failed++; $display("[TB] FAIL udiv_latency got %0d want 34", lat);
    end
    tests++;
    if (dbz !== 1'b0) begin
      failed++; $display("[TB] FAIL udiv_dbz got %b want 0", dbz);
    end
    release_all();
    tests++;
    if ({if32.ready_o, if32.result_o} !== 65'd0) begin
      failed++; $display("[TB] FAIL udiv_release got %h want 0", {if32.ready_o, if32.result_o});
    end
    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      exp = model32(1'b0, a, b);
      run32(1'b0, a, b, res, dbz, lat);
      tests++;
      if (res !== exp || lat !== 34) begin
        failed++; $display("[TB] FAIL udiv_rand %h/%h got %h lat %0d want %h lat 34", a, b, res, lat, exp);
      end
      release_all();
    end
  endtask

  // Signed divides: fixed cases then random operands.
  task automatic test_signed();
    logic [63:0] res, exp;
    logic [31:0] a, b;
    bit dbz;
    int lat;
    run32(1'b1, -32'sd7, 32'sd2, res, dbz, lat);
    tests++;
    if (res !== {32'hFFFFFFFF, 32'hFFFFFFFD}) begin
      failed++; $display("[TB] FAIL sdiv_m7_2 got %h want ffffffff_fffffffd", res);
    end
    release_all();
    run32(1'b1, 32'sd7, -32'sd2, res, dbz, lat);
    tests++;
    if (res !== {32'h1, 32'hFFFFFFFD}) begin
      failed++; $display("[TB] FAIL sdiv_7_m2 got %h want 00000001_fffffffd", res);
    end
    release_all();
    run32(1'b1, 32'h80000000, 32'hFFFFFFFF, res, dbz, lat);
    tests++;
    if (res !== {32'h0, 32'h80000000} || dbz !== 1'b0) begin
      failed++; $display("[TB] FAIL sdiv_min_m1 got %h dbz %b want 00000000_80000000 dbz 0", res, dbz);
    end
    release_all();
    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 2) == 0) ? 32'($signed(32'($urandom_range(0, 40))) - 20) : $urandom;
      if (b == 0) b = 32'd3;
      exp = model32(1'b1, a, b);
      run32(1'b1, a, b, res, dbz, lat);
      tests++;
      if (res !== exp || lat !== 34) begin
        failed++; $display("[TB] FAIL sdiv_rand %h/%h got %h lat %0d want %h lat 34", a, b, res, lat, exp);
      end
      release_all();
    end
  endtask

  // Zero divisor: fast path with flag, cleared when start drops.
  task automatic test_div_by_zero();
    logic [63:0] res;
    bit dbz;
    int lat;
    run32(1'b0, 32'd5, 32'd0, res, dbz, lat);
    tests++;
    if (lat !== 3 || dbz !== 1'b1 || res !== 64'd0) begin
      failed++; $display("[TB] FAIL dbz_5_0 got lat %0d dbz %b res %h want lat 3 dbz 1 res 0", lat, dbz, res);
    end
    release_all();
    tests++;
    if ({if32.ready_o, if32.div_by_zero_o} !== 2'b00) begin
      failed++; $display("[TB] FAIL dbz_release got %b want 00", {if32.ready_o, if32.div_by_zero_o});
    end
  endtask

  // Flush in the middle of a divide, then an immediate new divide.
  task automatic test_annul();
    logic [63:0] res;
    bit dbz, seen;
    int lat;
    if32.signed_div_i = 1'b0;
    if32.opdata1_i = 32'd100;
    if32.opdata2_i = 32'd7;
    if32.start_i = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    if32.annul_i = 1'b1;
    if32.start_i = 1'b0;
    @(posedge clk); #1;
    if32.annul_i = 1'b0;
    seen = (if32.ready_o !== 1'b0);
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (if32.ready_o !== 1'b0) seen = 1'b1;
    end
    tests++;
    if (seen) begin
      failed++; $display("[TB] FAIL annul_no_ready got ready high want never");
    end
    run32(1'b0, 32'd9, 32'd3, res, dbz, lat);
    tests++;
    if (res !== {32'd0, 32'd3} || lat !== 34) begin
      failed++; $display("[TB] FAIL annul_then_9_3 got %h lat %0d want 00000000_00000003 lat 34", res, lat);
    end
    release_all();
  endtask

  // Reset mid-divide discards it; start held through END keeps the result.
  task automatic test_reset_and_hold();
    logic [63:0] res;
    bit dbz, seen, bad;
    int lat;
    if32.signed_div_i = 1'b0;
    if32.opdata1_i = 32'd1000;
    if32.opdata2_i = 32'd9;
    if32.start_i = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    if32.start_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    tests++;
    if ({if32.ready_o, if32.div_by_zero_o, if32.result_o} !== 66'd0) begin
      failed++; $display("[TB] FAIL reset_mid got %h want 0", {if32.ready_o, if32.div_by_zero_o, if32.result_o});
    end
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (if32.ready_o !== 1'b0) seen = 1'b1;
    end
    tests++;
    if (seen) begin
      failed++; $display("[TB] FAIL reset_mid_no_ready got ready high want never");
    end
    run32(1'b0, 32'd1000, 32'd3, res, dbz, lat);
    bad = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if32.opdata1_i = $urandom;
      if32.opdata2_i = 32'd5;
      @(posedge clk); #1;
      if (if32.ready_o !== 1'b1 || if32.result_o !== {32'd1, 32'd333}) bad = 1'b1;
    end
    tests++;
    if (bad) begin
      failed++; $display("[TB] FAIL hold_end got %h ready %b want 00000001_0000014d ready 1", if32.result_o, if32.ready_o);
    end
    release_all();
  endtask

  // WIDTH=8 instance: overflow corner, latency and random operands.
  task automatic test_width8();
    logic [15:0] res, exp;
    logic [7:0] a, b;
    bit dbz, sgn;
    int lat, want_lat;
    run8(1'b1, 8'h80, 8'hFF, res, dbz, lat);
    tests++;
    if (res !== 16'h0080 || lat !== 10 || dbz !== 1'b0) begin
      failed++; $display("[TB] FAIL w8_min_m1 got %h lat %0d dbz %b want 0080 lat 10 dbz 0", res, lat, dbz);
    end
    release_all();
    for (int i = 0; i < 20; i++) begin
      sgn = 1'($urandom);
      a = 8'($urandom);
      b = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      exp = model8(sgn, a, b);
      want_lat = (b == 0) ? 3 : 10;
      run8(sgn, a, b, res, dbz, lat);
      tests++;
      if (res !== exp || lat !== want_lat || dbz !== (b == 0)) begin
        failed++;
        $display("[TB] FAIL w8_rand s%0d %h/%h got %h lat %0d dbz %b want %h lat %0d", sgn, a, b, res, lat, dbz, exp, want_lat);
      end
      release_all();
    end
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_by_zero();
    test_annul();
    test_reset_and_hold();
    test_width8();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
